// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch handshake between the control unit (master) and the instruction memory (slave)
// IMemRead/Address: request from master; Instr/opcode/IMemReady/IMemFault/Busy: response from slave
interface imem_responder_if;
  logic        IMemRead;
  logic [31:0] Address;
  logic [31:0] Instr;
  logic [6:0]  opcode;
  logic        IMemReady;
  logic        IMemFault;
  logic        Busy;
  modport master (output IMemRead, Address, input Instr, opcode, IMemReady, IMemFault, Busy);
  modport slave (input IMemRead, Address, output Instr, opcode, IMemReady, IMemFault, Busy);
endinterface

// File: rtl/imem_responder.sv
// imem_responder: instruction memory answering UC fetches after WAIT wait states, with fault reporting
// clk/reset: clock and sync active-high reset; bus: fetch handshake (slave side)
// LoadEn/LoadAddr/LoadData: side write port that fills the instruction array
module imem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT        = 2,
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_responder_if.slave          bus,
  input  logic                     LoadEn,
  input  logic [$clog2(DEPTH)-1:0] LoadAddr,
  input  logic [31:0]              LoadData
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t          state, nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx;
  logic            fault;
  logic [31:0]     instr;
  logic [31:0]     mem [DEPTH];
  logic            accept, bad, load;
  logic [AW-1:0]   rd_idx;
  // bits above the word-index range make the address out of range
  assign bad    = (|bus.Address[1:0]) || (|bus.Address[31:AW+2]);
  assign accept = state == S_IDLE && bus.IMemRead;
  // zero-wait fetches read straight from the incoming address on the acceptance edge
  assign rd_idx = state == S_IDLE ? bus.Address[AW+1:2] : idx;
  assign load   = (accept && !bad && WAIT == 0) || (state == S_WAIT && cnt == 4'd0);
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : nxt;
  always_comb begin
    nxt = state == S_IDLE ? (bus.IMemRead ? ((bad || WAIT == 0) ? S_RESP : S_WAIT) : S_IDLE)
        : state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT)
        : S_IDLE;
  end
  always_comb begin
    bus.Busy      = state != S_IDLE;
    bus.IMemReady = state == S_RESP && !fault;
    bus.IMemFault = state == S_RESP && fault;
    bus.Instr     = instr;
    bus.opcode    = instr[6:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 4'd0;
      idx   <= '0;
      fault <= 1'b0;
      instr <= RESET_INSTR;
    end else begin
      if (accept) begin
        idx   <= bus.Address[AW+1:2];
        fault <= bad;
        cnt   <= 4'(WAIT == 0 ? 0 : WAIT - 1);
      end else if (state == S_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (load) instr <= mem[rd_idx];
    end
  end
  // not reset: contents survive reset; same-edge write/read returns the old word
  always_ff @(posedge clk)
    if (LoadEn) mem[LoadAddr] <= LoadData;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the multicycle CPU. It is the memory side of the fetch interface whose request side is the control unit (UC): it accepts `IMemRead` fetch requests at a byte address, and after a programmable number of wait states it returns the 32-bit instruction and its opcode field. It also reports misaligned and out-of-range fetches. A side write port lets the bench or a boot loader fill the instruction array.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit instruction words; power of two, at least 4.
- `WAIT`, 2: wait states per fetch, range 0..15.
- `RESET_INSTR`, 32'h00000013: value `Instr` takes at reset (RISC-V NOP, `addi x0,x0,0`).

Ports:
- `clk`  in  1  the only clock; everything is updated on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IMemRead`  in  1  fetch request from the UC; level, sampled only in IDLE.
- `Address`  in  32  byte address of the fetch, sampled with the accepted request.
- `Instr`  out  32  last successfully fetched instruction, registered and held.
- `opcode`  out  7  `Instr[6:0]`.
- `IMemReady`  out  1  one-cycle pulse: fetch complete, `Instr` valid.
- `IMemFault`  out  1  one-cycle pulse: fetch rejected; `Instr` does not change.
- `Busy`  out  1  high whenever the state is not IDLE.
- `LoadEn`  in  1  write enable for the instruction array.
- `LoadAddr`  in  $clog2(DEPTH)  word index to write.
- `LoadData`  in  32  word to write.

## Operation

- The state machine has three states: IDLE, WAIT, RESP. A 4-bit counter `cnt` drives WAIT.
- **IDLE**, with `IMemRead`=1 (acceptance):
  - Latch `Address[31:2]` as the word index and evaluate the fault condition.
  - Fault condition: `Address[1:0]` is not 0, or the word index is DEPTH or higher.
  - On a fault, go to RESP with the fault flag set, regardless of `WAIT`.
  - Otherwise, if `WAIT`=0, go to RESP.
  - Otherwise, go to WAIT with `cnt` set to `WAIT`-1.
- **IDLE**, with `IMemRead`=0: stay in IDLE.
- **WAIT**: if `cnt`=0, go to RESP and load `Instr` from the array at the latched index; otherwise decrement `cnt`.
- **RESP**:
  - Without fault: `IMemReady`=1.
  - With fault: `IMemFault`=1, and `Instr` is not loaded.
  - Always return to IDLE on the next edge. `IMemRead` is ignored in RESP.
- For the `WAIT`=0 path, `Instr` is loaded at the edge that enters RESP.
- `Address` and `IMemRead` changes are ignored while `Busy` is high.
- Array writes:
  - `LoadEn` writes `LoadData` to `LoadAddr` on any edge, in any state.
  - The read is read-first: a write on the same edge that loads `Instr` from the same word returns the old contents.
- The array is not cleared by reset. Contents persist across resets.

## Timing

- Reset values: state IDLE, `cnt`=0, `Instr`=`RESET_INSTR`, `opcode`=`RESET_INSTR[6:0]` (7'b0010011), `IMemReady`=0, `IMemFault`=0, `Busy`=0.
- Number the acceptance edge as edge 0.
  - Good fetch: `IMemReady` and the new `Instr` are visible in the cycle after edge `WAIT`.
  - Fault: `IMemFault` is visible in the cycle after edge 0.
- `Busy` is high for `WAIT`+1 cycles on a good fetch and 1 cycle on a fault.
- Throughput with `IMemRead` held high: one fetch per `WAIT`+2 cycles. The next acceptance is at edge `WAIT`+2.
- `IMemReady` and `IMemFault` are never high in the same cycle, and each is at most one cycle wide.
- Reset asserted in WAIT or RESP aborts the fetch. The next cycle shows reset values, with no Ready or Fault pulse.
- `opcode` always equals `Instr[6:0]` in the same cycle.

## Test plan

- **Reset**: hold `reset` for 2 cycles. Then `Instr`=32'h00000013, `opcode`=7'b0010011, `IMemReady`=`IMemFault`=`Busy`=0.
- **Single fetch**, `WAIT`=2: load word 0 with 32'h00500093, then pulse `IMemRead` with `Address`=0.
  - `Busy` is high for 3 cycles.
  - `IMemReady` pulses in the cycle after edge 2.
  - `Instr`=32'h00500093 and `opcode`=7'b0010011.
- **Misaligned**: `Address`=32'h2.
  - `IMemFault` pulses in the cycle after the acceptance edge, and `IMemReady` stays 0.
  - `Instr` keeps its previous value.
- **Out of range**, `DEPTH`=256: `Address`=32'h400 gives a `IMemFault` pulse with `Instr` unchanged. `Address`=32'h3FC is accepted normally.
- **Reset mid-fetch**: assert `reset` one cycle after acceptance with `WAIT`=2. No `IMemReady` appears, `Instr`=32'h00000013, and `Busy`=0.
- **Back-to-back**: words 0 and 1 hold 32'h00500093 and 32'h00A00113; hold `IMemRead`=1, and change `Address` 0→4 while `Busy` is high.
  - The first fetch returns word 0.
  - The second acceptance is at edge 4 (`WAIT`=2) and returns 32'h00A00113.
  - The `IMemReady` pulses are 4 cycles apart.
